// File: rtl/jfpjc_pkg.sv
// jfpjc_pkg: framer state encoding and JPEG marker constants.
package jfpjc_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, BODY, EOI_FF, EOI_D9} state_t;
  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI = 8'hD9;
  localparam logic [7:0] JPEG_STUFF = 8'h00;
endpackage

// File: rtl/jfpjc_byte_fifo.sv
// jfpjc_byte_fifo: first-word-fall-through byte FIFO, DEPTH a power of two.
module jfpjc_byte_fifo #(
  parameter int DEPTH = 32
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0] mem_q [DEPTH];
  logic do_wr, do_rd;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign dout = mem_q[rd_ptr_q[AW-1:0]];
  // a pop in the same cycle frees the slot a full-FIFO write needs
  always_comb begin
    do_rd = rd_en && !empty;
    do_wr = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/jfpjc_jpeg_framer.sv
// jfpjc_jpeg_framer: wraps buffered scan bytes with EBR header and EOI marker.
// Define JFPJC_FRAMER_BYTE_STUFF_EN to insert 0x00 after every 0xFF scan byte.
module jfpjc_jpeg_framer
  import jfpjc_pkg::*;
#(
  parameter int HEADER_LEN = 328,
  parameter int HDR_ADDR_W = 9,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic [HDR_ADDR_W-1:0] header_ebr_raddr,
  output logic                  header_ebr_ren,
  input  logic [7:0]            header_ebr_dout,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_error
);
  localparam logic [HDR_ADDR_W:0] HDR_END = (HDR_ADDR_W+1)'(HEADER_LEN);
  state_t state_q, state_d;
  logic [HDR_ADDR_W:0] addr_q, addr_d;
  logic pend_q, pend_d, end_q, end_d, stuff_q, stuff_d;
  logic out_valid_q, out_valid_d, busy_q, busy_d;
  logic overflow_q, overflow_d, frame_error_q, frame_error_d;
  logic [7:0] out_data_q, out_data_d, fifo_dout;
  logic take, ren, pop, wr, fifo_full, fifo_empty;
  jfpjc_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock  (clock),
    .nreset (nreset),
    .wr_en  (wr),
    .din    (in_data),
    .full   (fifo_full),
    .rd_en  (pop),
    .dout   (fifo_dout),
    .empty  (fifo_empty)
  );
  assign header_ebr_raddr = addr_q[HDR_ADDR_W-1:0];
  assign header_ebr_ren = ren;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign busy = busy_q;
  assign overflow = overflow_q;
  assign frame_error = frame_error_q;
  // a header read is only issued when the output slot is certain to be free when its data lands
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    pend_d = 1'b0;
    end_d = (frame_end && state_q != IDLE) ? 1'b1 : end_q;
    stuff_d = stuff_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d = out_data_q;
    ren = 1'b0;
    pop = 1'b0;
    take = !out_valid_q || out_ready;
    wr = in_valid && state_q != IDLE;
    frame_error_d = frame_error_q || (frame_start && state_q != IDLE);
    case (state_q)
      IDLE: if (frame_start) begin
        state_d = HEADER;
        addr_d = '0;
      end
      HEADER: if (pend_q) begin
        out_valid_d = 1'b1;
        out_data_d = header_ebr_dout;
      end else if (take && addr_q == HDR_END) begin
        state_d = BODY;
        addr_d = '0;
      end else if (take) begin
        ren = 1'b1;
        pend_d = 1'b1;
        addr_d = addr_q + 1'b1;
      end
      BODY: if (take) begin
        if (stuff_q) begin
          out_valid_d = 1'b1;
          out_data_d = JPEG_STUFF;
          stuff_d = 1'b0;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          out_valid_d = 1'b1;
          out_data_d = fifo_dout;
`ifdef JFPJC_FRAMER_BYTE_STUFF_EN
          stuff_d = fifo_dout == JPEG_MARKER_PREFIX;
`endif
        end else if (end_q) begin
          out_valid_d = 1'b1;
          out_data_d = JPEG_MARKER_PREFIX;
          state_d = EOI_FF;
        end
      end
      EOI_FF: if (out_ready) begin
        out_valid_d = 1'b1;
        out_data_d = JPEG_EOI;
        state_d = EOI_D9;
      end
      EOI_D9: if (out_ready) begin
        state_d = IDLE;
        end_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    overflow_d = overflow_q || (wr && fifo_full && !pop);
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      addr_q <= '0;
      pend_q <= 1'b0;
      end_q <= 1'b0;
      stuff_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      busy_q <= 1'b0;
      overflow_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      end_q <= end_d;
      stuff_q <= stuff_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      busy_q <= busy_d;
      overflow_q <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end
endmodule

// File: tb/tb_jfpjc_jpeg_framer.sv
// tb_jfpjc_jpeg_framer: directed frames against a byte-order model of header, scan and EOI.
module tb_jfpjc_jpeg_framer;
  localparam int HEADER_LEN = 328;
  logic clock = 1'b0;
  logic nreset, frame_start, frame_end, in_valid, out_ready;
  logic [7:0] in_data, header_ebr_dout, out_data;
  logic [8:0] header_ebr_raddr;
  logic header_ebr_ren, out_valid, busy, overflow, frame_error;
  int checks = 0, errors = 0;
  bit rnd = 0, seen_ren = 0, prev_stall = 0;
  logic [8:0] first_raddr = '0;
  logic [7:0] prev_data = '0;
  logic [7:0] got[$], body[$];
  jfpjc_jpeg_framer dut (
    .clock            (clock),
    .nreset           (nreset),
    .frame_start      (frame_start),
    .frame_end        (frame_end),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .header_ebr_raddr (header_ebr_raddr),
    .header_ebr_ren   (header_ebr_ren),
    .header_ebr_dout  (header_ebr_dout),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .busy             (busy),
    .overflow         (overflow),
    .frame_error      (frame_error)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (header_ebr_ren) header_ebr_dout <= header_ebr_raddr[7:0];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clock) begin
    if (!nreset) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 1);
        chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (header_ebr_ren && !seen_ren) begin
        seen_ren = 1;
        first_raddr = header_ebr_raddr;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic start_frame();
    got.delete();
    body.delete();
    seen_ren = 0;
    frame_start = 1;
    step();
    frame_start = 0;
  endtask
  task automatic send(input logic [7:0] b, input bit last_end);
    in_valid = 1;
    in_data = b;
    frame_end = last_end;
    body.push_back(b);
    step();
    in_valid = 0;
    frame_end = 0;
  endtask
  task automatic end_frame();
    frame_end = 1;
    step();
    frame_end = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 0);
  endtask
  task automatic wait_got(input int target);
    int n = 0;
    while (got.size() < target && n < 5000) begin
      step();
      n++;
    end
    chk("got_timeout", {31'd0, got.size() >= target}, 1);
  endtask
  task automatic compare(input string tag);
    logic [7:0] exp[$];
    for (int i = 0; i < HEADER_LEN; i++) exp.push_back(i[7:0]);
    foreach (body[i]) begin
      exp.push_back(body[i]);
`ifdef JFPJC_FRAMER_BYTE_STUFF_EN
      if (body[i] == 8'hFF) exp.push_back(8'h00);
`endif
    end
    exp.push_back(8'hFF);
    exp.push_back(8'hD9);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
  endtask
  task automatic basic_frame(input string tag);
    start_frame();
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 0);
    end_frame();
    wait_idle();
    compare(tag);
    chk({tag, "_first_raddr"}, {23'd0, first_raddr}, 0);
  endtask
  initial begin
    nreset = 0;
    frame_start = 0;
    frame_end = 0;
    in_valid = 0;
    in_data = 0;
    out_ready = 1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ren", {31'd0, header_ebr_ren}, 0);
    chk("rst_raddr", {23'd0, header_ebr_raddr}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_frame_error", {31'd0, frame_error}, 0);
    @(negedge clock);
    nreset = 1;
    step();
    basic_frame("basic");
    chk("basic_overflow", {31'd0, overflow}, 0);
    chk("basic_frame_error", {31'd0, frame_error}, 0);
    rnd = 1;
    basic_frame("backpressure");
    rnd = 0;
    out_ready = 1;
    start_frame();
    end_frame();
    wait_idle();
    compare("empty");
    start_frame();
    send(8'h21, 0);
    send(8'h22, 0);
    send(8'h23, 1);
    wait_idle();
    compare("same_end");
    start_frame();
    send(8'hFF, 0);
    send(8'h12, 0);
    end_frame();
    wait_idle();
    compare("stuff");
    out_ready = 0;
    start_frame();
    for (int i = 0; i < 33; i++) send(8'h40 + 8'(i), 0);
    void'(body.pop_back());
    end_frame();
    chk("overflow_set", {31'd0, overflow}, 1);
    out_ready = 1;
    wait_idle();
    compare("overflow");
    start_frame();
    send(8'h31, 0);
    send(8'h32, 0);
    wait_got(HEADER_LEN + 2);
    frame_start = 1;
    step();
    frame_start = 0;
    chk("frame_error_set", {31'd0, frame_error}, 1);
    end_frame();
    wait_idle();
    compare("error_frame");
    start_frame();
    repeat (10) step();
    chk("pre_rst_busy", {31'd0, busy}, 1);
    nreset = 0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_ren", {31'd0, header_ebr_ren}, 0);
    chk("arst_raddr", {23'd0, header_ebr_raddr}, 0);
    chk("arst_overflow", {31'd0, overflow}, 0);
    chk("arst_frame_error", {31'd0, frame_error}, 0);
    step();
    nreset = 1;
    step();
    basic_frame("after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
